// File: rtl/jump_ctrl_if.sv
// Branch-command / PC-control bundle shared by the decoder side (master) and jump_ctrl (slave).
// Widths follow the jump_ctrl parameters: D address bits, L LUT index bits, S link-stack entries.
interface jump_ctrl_if #(
   parameter int D = 10,
   parameter int L = 4,
   parameter int S = 4
);
   localparam int SW = $clog2(S + 1);

   logic [2:0]    br_op;
   logic [L-1:0]  lut_idx;
   logic [D-1:0]  prog_ctr;
   logic          zero_in;
   logic          flag_wr;
   logic          lut_we;
   logic [L-1:0]  lut_waddr;
   logic [D-1:0]  lut_wdata;
   logic          jmp_en;
   logic          absjump_en;
   logic [D-1:0]  target;
   logic [D-1:0]  absaddress;
   logic [SW-1:0] stk_depth;
   logic          stk_ovf;
   logic          stk_udf;

   modport master (
      output br_op, lut_idx, prog_ctr, zero_in, flag_wr, lut_we, lut_waddr, lut_wdata,
      input  jmp_en, absjump_en, target, absaddress, stk_depth, stk_ovf, stk_udf
   );

   modport slave (
      input  br_op, lut_idx, prog_ctr, zero_in, flag_wr, lut_we, lut_waddr, lut_wdata,
      output jmp_en, absjump_en, target, absaddress, stk_depth, stk_ovf, stk_udf
   );
endinterface

// File: rtl/jump_ctrl.sv
// Branch command decoder for the PC: zero flag, relative-offset LUT and an optional link stack.
// Define LINK_STACK_EN to build the CALL/RET link stack; otherwise CALL acts as JMP and RET as NOP.
module jump_ctrl #(
   parameter int D = 10,
   parameter int L = 4,
   parameter int S = 4
) (
   input logic        clk,
   input logic        reset,
   jump_ctrl_if.slave bus
);
   localparam int SW = $clog2(S + 1);

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_JMP  = 3'b001,
      OP_BZ   = 3'b010,
      OP_BNZ  = 3'b011,
      OP_CALL = 3'b100,
      OP_RET  = 3'b101,
      OP_RSV6 = 3'b110,
      OP_RSV7 = 3'b111
   } br_op_t;

   br_op_t       op;
   logic         flag_q;
   logic [D-1:0] lut_q [2**L];
   logic [D-1:0] lut_rd;
   logic         jmp;
   logic         abs_jmp;
   logic [D-1:0] tgt;
   logic [D-1:0] abs_addr;

   assign op     = br_op_t'(bus.br_op);
   assign lut_rd = lut_q[bus.lut_idx];

`ifdef LINK_STACK_EN
   localparam int AW = (S > 1) ? $clog2(S) : 1;

   logic [D-1:0]  stk_mem [S];
   logic [SW-1:0] depth_q;
   logic          ovf_q;
   logic          udf_q;
   logic [AW-1:0] top_idx;
   logic [AW-1:0] push_idx;
   logic          stk_full;
   logic          stk_empty;
   logic          do_push;
   logic          do_pop;
   logic          set_ovf;
   logic          set_udf;

   assign stk_full  = (depth_q == SW'(S));
   assign stk_empty = (depth_q == '0);
   assign top_idx   = AW'(depth_q - SW'(1));
   assign push_idx  = AW'(depth_q);
`else
   logic unused_prog_ctr;
   assign unused_prog_ctr = ^bus.prog_ctr;
`endif

   // Jump decode is purely combinational so the PC can sample it on the same edge
   // that updates the flag, LUT and stack; a CALL on a full stack still jumps.
   always_comb begin
      jmp      = 1'b0;
      abs_jmp  = 1'b0;
      tgt      = '0;
      abs_addr = '0;
`ifdef LINK_STACK_EN
      do_push  = 1'b0;
      do_pop   = 1'b0;
      set_ovf  = 1'b0;
      set_udf  = 1'b0;
`endif
      case (op)
         OP_JMP: begin
            jmp = 1'b1;
            tgt = lut_rd;
         end
         OP_BZ: begin
            jmp = flag_q;
            tgt = lut_rd;
         end
         OP_BNZ: begin
            jmp = ~flag_q;
            tgt = lut_rd;
         end
         OP_CALL: begin
            jmp = 1'b1;
            tgt = lut_rd;
`ifdef LINK_STACK_EN
            if (stk_full) set_ovf = 1'b1;
            else          do_push = 1'b1;
`endif
         end
`ifdef LINK_STACK_EN
         OP_RET: begin
            if (!stk_empty) begin
               jmp      = 1'b1;
               abs_jmp  = 1'b1;
               abs_addr = stk_mem[top_idx];
               do_pop   = 1'b1;
            end else begin
               set_udf  = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   // The flag written this cycle only steers branches from the next cycle on,
   // and a LUT write never bypasses to a same-cycle read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_q <= 1'b0;
         for (int i = 0; i < 2**L; i++) lut_q[i] <= '0;
      end else begin
         if (bus.flag_wr) flag_q <= bus.zero_in;
         if (bus.lut_we)  lut_q[bus.lut_waddr] <= bus.lut_wdata;
      end
   end

`ifdef LINK_STACK_EN
   // Occupancy and sticky error bits; clearing the depth empties the stack at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (do_push)     depth_q <= depth_q + SW'(1);
         else if (do_pop) depth_q <= depth_q - SW'(1);
         if (set_ovf) ovf_q <= 1'b1;
         if (set_udf) udf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) stk_mem[push_idx] <= bus.prog_ctr + D'(1);
   end

   assign bus.stk_depth = depth_q;
   assign bus.stk_ovf   = ovf_q;
   assign bus.stk_udf   = udf_q;
`else
   assign bus.stk_depth = '0;
   assign bus.stk_ovf   = 1'b0;
   assign bus.stk_udf   = 1'b0;
`endif

   assign bus.jmp_en     = jmp;
   assign bus.absjump_en = abs_jmp;
   assign bus.target     = tgt;
   assign bus.absaddress = abs_addr;
endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl against a queue/array reference model.
// Builds with or without LINK_STACK_EN; the model follows the same macro.
module tb_jump_ctrl;
   localparam int D  = 10;
   localparam int L  = 4;
   localparam int S  = 4;
   localparam int SW = $clog2(S + 1);

   logic clk = 1'b0;
   logic reset;

   jump_ctrl_if #(.D(D), .L(L), .S(S)) bus ();
   jump_ctrl #(.D(D), .L(L), .S(S)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [D-1:0] m_lut [2**L];
   logic         m_flag;
   logic [D-1:0] m_stk [$];
   logic         m_ovf;
   logic         m_udf;
   logic         e_jmp;
   logic         e_abs;
   logic [D-1:0] e_tgt;
   logic [D-1:0] e_addr;
   logic [2:0]   c_op;
   logic [D-1:0] c_pc;
   logic         c_fw, c_z, c_we;
   logic [L-1:0] c_wa;
   logic [D-1:0] c_wd;

   task automatic model_reset();
      m_flag = 1'b0;
      foreach (m_lut[i]) m_lut[i] = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.br_op = 3'b000; bus.lut_idx = '0; bus.prog_ctr = '0; bus.zero_in = 1'b0;
      bus.flag_wr = 1'b0; bus.lut_we = 1'b0; bus.lut_waddr = '0; bus.lut_wdata = '0;
      c_op = 3'b000; c_pc = '0; c_fw = 1'b0; c_z = 1'b0; c_we = 1'b0; c_wa = '0; c_wd = '0;
   endtask

   // Drive one command between edges and work out what the PC should see this cycle.
   task automatic drive(input logic [2:0] op, input logic [L-1:0] idx, input logic [D-1:0] pc,
                        input logic fw = 1'b0, input logic z = 1'b0, input logic we = 1'b0,
                        input logic [L-1:0] wa = '0, input logic [D-1:0] wd = '0);
      @(negedge clk);
      bus.br_op = op; bus.lut_idx = idx; bus.prog_ctr = pc; bus.flag_wr = fw; bus.zero_in = z;
      bus.lut_we = we; bus.lut_waddr = wa; bus.lut_wdata = wd;
      c_op = op; c_pc = pc; c_fw = fw; c_z = z; c_we = we; c_wa = wa; c_wd = wd;
      e_jmp = 1'b0; e_abs = 1'b0; e_tgt = '0; e_addr = '0;
      case (op)
         3'b001, 3'b100: begin e_jmp = 1'b1;    e_tgt = m_lut[idx]; end
         3'b010:         begin e_jmp = m_flag;  e_tgt = m_lut[idx]; end
         3'b011:         begin e_jmp = !m_flag; e_tgt = m_lut[idx]; end
`ifdef LINK_STACK_EN
         3'b101: if (m_stk.size() != 0) begin
            e_jmp = 1'b1; e_abs = 1'b1; e_addr = m_stk[$];
         end
`endif
         default: ;
      endcase
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
`ifdef LINK_STACK_EN
      if (c_op == 3'b100) begin
         if (m_stk.size() < S) m_stk.push_back(D'((int'(c_pc) + 1) % (1 << D)));
         else m_ovf = 1'b1;
      end
      if (c_op == 3'b101) begin
         if (m_stk.size() > 0) void'(m_stk.pop_back());
         else m_udf = 1'b1;
      end
`endif
      if (c_fw) m_flag = c_z;
      if (c_we) m_lut[c_wa] = c_wd;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      model_reset();
      #1;
      total++; if (bus.jmp_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_jmp got=%b want=0", bus.jmp_en); end
      total++; if (bus.absjump_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_abs got=%b want=0", bus.absjump_en); end
      total++; if (bus.target !== '0) begin bad++; $display("[TB] FAIL reset_target got=%h want=0", bus.target); end
      total++; if (bus.absaddress !== '0) begin bad++; $display("[TB] FAIL reset_absaddr got=%h want=0", bus.absaddress); end
      total++; if (bus.stk_depth !== '0) begin bad++; $display("[TB] FAIL reset_depth got=%0d want=0", bus.stk_depth); end
      total++; if ({bus.stk_ovf, bus.stk_udf} !== 2'b00) begin bad++; $display("[TB] FAIL reset_sticky got=%b want=00", {bus.stk_ovf, bus.stk_udf}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_jmp();
      drive(3'b000, 4'd0, 10'd0, 1'b0, 1'b0, 1'b1, 4'd3, 10'd5);
      total++; if (bus.jmp_en !== 1'b0) begin bad++; $display("[TB] FAIL nop_jmp got=%b want=0", bus.jmp_en); end
      tick();
      drive(3'b001, 4'd3, 10'd7);
      total++; if (bus.jmp_en !== 1'b1) begin bad++; $display("[TB] FAIL jmp_en got=%b want=1", bus.jmp_en); end
      total++; if (bus.absjump_en !== 1'b0) begin bad++; $display("[TB] FAIL jmp_abs got=%b want=0", bus.absjump_en); end
      total++; if (bus.target !== 10'd5) begin bad++; $display("[TB] FAIL jmp_target got=%h want=005", bus.target); end
      tick();
   endtask

   task automatic test_branch_flag();
      drive(3'b010, 4'd3, 10'd0, 1'b1, 1'b1);
      total++; if (bus.jmp_en !== e_jmp) begin bad++; $display("[TB] FAIL bz_same_cycle got=%b want=%b", bus.jmp_en, e_jmp); end
      tick();
      drive(3'b010, 4'd3, 10'd0);
      total++; if (bus.jmp_en !== e_jmp) begin bad++; $display("[TB] FAIL bz_next_cycle got=%b want=%b", bus.jmp_en, e_jmp); end
      total++; if (bus.target !== e_tgt) begin bad++; $display("[TB] FAIL bz_target got=%h want=%h", bus.target, e_tgt); end
      tick();
      drive(3'b011, 4'd3, 10'd0, 1'b1, 1'b0);
      total++; if (bus.jmp_en !== e_jmp) begin bad++; $display("[TB] FAIL bnz_flag1 got=%b want=%b", bus.jmp_en, e_jmp); end
      tick();
      drive(3'b011, 4'd3, 10'd0);
      total++; if (bus.jmp_en !== e_jmp) begin bad++; $display("[TB] FAIL bnz_flag0 got=%b want=%b", bus.jmp_en, e_jmp); end
      tick();
   endtask

   task automatic test_call_ret();
      drive(3'b100, 4'd3, 10'd20);
      total++; if ({bus.jmp_en, bus.target} !== {e_jmp, e_tgt}) begin bad++; $display("[TB] FAIL call1 got=%b/%h want=%b/%h", bus.jmp_en, bus.target, e_jmp, e_tgt); end
      tick();
      drive(3'b100, 4'd3, 10'd40);
      tick();
      total++; if (bus.stk_depth !== SW'(m_stk.size())) begin bad++; $display("[TB] FAIL call_depth got=%0d want=%0d", bus.stk_depth, m_stk.size()); end
      for (int k = 0; k < 2; k++) begin
         drive(3'b101, 4'd0, 10'd0);
         total++; if ({bus.jmp_en, bus.absjump_en} !== {e_jmp, e_abs}) begin bad++; $display("[TB] FAIL ret_en got=%b%b want=%b%b", bus.jmp_en, bus.absjump_en, e_jmp, e_abs); end
         total++; if (bus.absaddress !== e_addr) begin bad++; $display("[TB] FAIL ret_addr got=%0d want=%0d", bus.absaddress, e_addr); end
         tick();
         total++; if (bus.stk_depth !== SW'(m_stk.size())) begin bad++; $display("[TB] FAIL ret_depth got=%0d want=%0d", bus.stk_depth, m_stk.size()); end
      end
   endtask

   task automatic test_overflow();
      for (int k = 0; k <= S; k++) begin
         drive(3'b100, 4'd3, D'(100 + k));
         total++; if (bus.jmp_en !== 1'b1) begin bad++; $display("[TB] FAIL ovf_call_taken got=%b want=1", bus.jmp_en); end
         tick();
      end
      total++; if (bus.stk_depth !== SW'(m_stk.size())) begin bad++; $display("[TB] FAIL ovf_depth got=%0d want=%0d", bus.stk_depth, m_stk.size()); end
      total++; if (bus.stk_ovf !== m_ovf) begin bad++; $display("[TB] FAIL ovf_sticky got=%b want=%b", bus.stk_ovf, m_ovf); end
      for (int k = 0; k <= S; k++) begin
         drive(3'b101, 4'd0, 10'd0);
         total++; if ({bus.jmp_en, bus.absaddress} !== {e_jmp, e_addr}) begin bad++; $display("[TB] FAIL ovf_ret got=%b/%0d want=%b/%0d", bus.jmp_en, bus.absaddress, e_jmp, e_addr); end
         tick();
      end
      total++; if (bus.stk_depth !== '0) begin bad++; $display("[TB] FAIL udf_depth got=%0d want=0", bus.stk_depth); end
      total++; if (bus.stk_udf !== m_udf) begin bad++; $display("[TB] FAIL udf_sticky got=%b want=%b", bus.stk_udf, m_udf); end
      total++; if (bus.stk_ovf !== m_ovf) begin bad++; $display("[TB] FAIL ovf_stays got=%b want=%b", bus.stk_ovf, m_ovf); end
   endtask

   task automatic test_wrap();
      drive(3'b100, 4'd3, 10'd1023);
      tick();
      drive(3'b101, 4'd0, 10'd0);
      total++; if ({bus.absjump_en, bus.absaddress} !== {e_abs, e_addr}) begin bad++; $display("[TB] FAIL wrap_ret got=%b/%h want=%b/%h", bus.absjump_en, bus.absaddress, e_abs, e_addr); end
      tick();
      drive(3'b000, 4'd0, 10'd0, 1'b0, 1'b0, 1'b1, 4'd2, 10'h3FD);
      tick();
      drive(3'b001, 4'd2, 10'd0);
      total++; if (bus.target !== 10'h3FD) begin bad++; $display("[TB] FAIL neg_offset got=%h want=3fd", bus.target); end
      tick();
   endtask

   task automatic test_async_reset();
      drive(3'b101, 4'd0, 10'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(3'b100, 4'd1, D'(200 + k));
         tick();
      end
      total++; if ({bus.stk_depth, bus.stk_udf} !== {SW'(m_stk.size()), m_udf}) begin bad++; $display("[TB] FAIL pre_reset got=%0d/%b want=%0d/%b", bus.stk_depth, bus.stk_udf, m_stk.size(), m_udf); end
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      total++; if (bus.stk_depth !== '0) begin bad++; $display("[TB] FAIL async_depth got=%0d want=0", bus.stk_depth); end
      total++; if ({bus.stk_ovf, bus.stk_udf} !== 2'b00) begin bad++; $display("[TB] FAIL async_sticky got=%b want=00", {bus.stk_ovf, bus.stk_udf}); end
      reset = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(3'($urandom_range(0, 7)), L'($urandom), D'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), L'($urandom), D'($urandom));
         total++; if ({bus.jmp_en, bus.absjump_en, bus.target, bus.absaddress} !== {e_jmp, e_abs, e_tgt, e_addr})
            begin bad++; $display("[TB] FAIL rand_out op=%0d got=%b%b/%h/%h want=%b%b/%h/%h", c_op, bus.jmp_en, bus.absjump_en, bus.target, bus.absaddress, e_jmp, e_abs, e_tgt, e_addr); end
         tick();
         total++; if ({bus.stk_depth, bus.stk_ovf, bus.stk_udf} !== {SW'(m_stk.size()), m_ovf, m_udf})
            begin bad++; $display("[TB] FAIL rand_state got=%0d/%b/%b want=%0d/%b/%b", bus.stk_depth, bus.stk_ovf, bus.stk_udf, m_stk.size(), m_ovf, m_udf); end
      end
   endtask

   initial begin
      test_reset();
      test_jmp();
      test_branch_flag();
      test_call_ret();
      test_overflow();
      test_wrap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
